writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_pkg.sv | 22 ++
 rtl/writeback_unit_wb_fifo.sv | 55 +++++
 rtl/writeback_unit.sv | 77 +++++++
 tb/tb_writeback_unit.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_unit_pkg.sv
// rtl/writeback_unit_pkg.sv - shared CPU constants and writeback entry types
package writeback_unit_pkg;

  // Datapath width and register-address width shared with the decoder
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xdata_t;

  // One pending result waiting for the register-file write port
  typedef struct packed {
    reg_addr_t rd;
    xdata_t    data;
  } wb_entry_t;

  // x0 is hard-wired to zero, so results aimed at it are never stored
  function automatic logic is_x0(input reg_addr_t addr);
    return addr == '0;
  endfunction

endpackage

// File: rtl/writeback_unit_wb_fifo.sv
// rtl/writeback_unit_wb_fifo.sv - circular storage of pending writeback results
module wb_fifo
  import writeback_unit_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output logic [CNT_W-1:0]      count,
  output logic [PTR_W-1:0]      head_ptr,
  output wb_entry_t             head_entry,
  output wb_entry_t [DEPTH-1:0] entries
);

  wb_entry_t [DEPTH-1:0] mem;
  logic [PTR_W-1:0]      tail_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Overflow and underflow are blocked here as well, so the pointers stay coherent
  assign do_push = push & (count != CNT_W'(DEPTH));
  assign do_pop  = pop & (count != '0);

  assign head_entry = mem[head_ptr];
  assign entries    = mem;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem      <= '0;
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (do_push) begin
        mem[tail_ptr] <= push_entry;
        tail_ptr      <= tail_ptr + 1'b1;
      end
      if (do_pop) begin
        head_ptr <= head_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - buffers execute results, drives the register-file write port, forwards pending values
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  wb_en,
  output logic                  wen,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [XLEN-1:0]       wdata,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [XLEN-1:0]       fwd_data,
  output logic [CNT_W-1:0]      pending
);

  logic                  push;
  logic                  pop;
  logic                  not_empty;
  logic [PTR_W-1:0]      head_ptr;
  logic [PTR_W-1:0]      scan_idx;
  wb_entry_t             head_entry;
  wb_entry_t             push_entry;
  wb_entry_t [DEPTH-1:0] entries;

  // Ready depends only on the stored count, never on wb_en or in_valid
  assign in_ready  = pending < CNT_W'(DEPTH);
  assign not_empty = pending != '0;

  // Accepted x0 results are consumed but never stored
  assign push       = in_valid & in_ready & ~is_x0(in_rd);
  assign push_entry = '{rd: in_rd, data: in_data};

  // Head is written whenever the port is free and something is waiting
  assign wen   = not_empty & wb_en;
  assign pop   = wen;
  assign waddr = not_empty ? head_entry.rd : '0;
  assign wdata = not_empty ? head_entry.data : '0;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .count     (pending),
    .head_ptr  (head_ptr),
    .head_entry(head_entry),
    .entries   (entries)
  );

  // Scan oldest to youngest so the last match, the youngest, wins
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    scan_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = head_ptr + PTR_W'(k);
      if ((CNT_W'(k) < pending) && !is_x0(fwd_addr) &&
          (entries[scan_idx].rd == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = entries[scan_idx].data;
      end
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - table-driven and scoreboard checks of writeback_unit
module tb_writeback_unit;

  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rd;
  logic [31:0]   in_data;
  logic          wb_en;
  logic          wen;
  logic [4:0]    waddr;
  logic [31:0]   wdata;
  logic [4:0]    fwd_addr;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [CW-1:0] pending;

  always #5 clk = ~clk;

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_rd   (in_rd),
    .in_data (in_data),
    .wb_en   (wb_en),
    .wen     (wen),
    .waddr   (waddr),
    .wdata   (wdata),
    .fwd_addr(fwd_addr),
    .fwd_hit (fwd_hit),
    .fwd_data(fwd_data),
    .pending (pending)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        we;
    logic [4:0]  fa;
    logic        e_rdy;
    logic [1:0]  e_pend;
    logic        e_wen;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_hit;
    logic [31:0] e_fd;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } ent_t;

  ent_t       sb_q[$];
  logic [4:0] wr_log[$];
  vec_t       vecs[14];
  int         n_pass  = 0;
  int         n_total = 0;
  int         pmax;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic apply(input logic v, input logic [4:0] rd, input logic [31:0] d,
                       input logic we, input logic [4:0] fa);
    in_valid = v;
    in_rd    = rd;
    in_data  = d;
    wb_en    = we;
    fwd_addr = fa;
    #2;
  endtask

  // Compare against the scoreboard, update it for this edge, then advance one cycle
  task automatic model_step();
    logic        m_rdy;
    logic        m_wen;
    logic        m_hit;
    logic [31:0] m_fd;
    m_rdy = sb_q.size() < DEPTH;
    m_wen = (sb_q.size() != 0) && wb_en;
    chk("sb_in_ready", in_ready, m_rdy);
    chk("sb_pending", pending, sb_q.size());
    chk("sb_wen", wen, m_wen);
    if (sb_q.size() != 0) begin
      chk("sb_waddr", waddr, sb_q[0].rd);
      chk("sb_wdata", wdata, sb_q[0].d);
    end else begin
      chk("sb_waddr_empty", waddr, 0);
      chk("sb_wdata_empty", wdata, 0);
    end
    m_hit = 1'b0;
    m_fd  = 32'h0;
    if (fwd_addr != 0) begin
      for (int i = sb_q.size() - 1; i >= 0; i--) begin
        if (sb_q[i].rd == fwd_addr) begin
          m_hit = 1'b1;
          m_fd  = sb_q[i].d;
          break;
        end
      end
    end
    chk("sb_fwd_hit", fwd_hit, m_hit);
    chk("sb_fwd_data", fwd_data, m_fd);
    if (int'(pending) > pmax) pmax = int'(pending);
    if (wen === 1'b1) wr_log.push_back(waddr);
    if (m_wen) void'(sb_q.pop_front());
    if (in_valid && m_rdy && in_rd != 0) sb_q.push_back('{in_rd, in_data});
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic v, input logic [4:0] rd, input logic [31:0] d,
                     input logic we, input logic [4:0] fa);
    apply(v, rd, d, we, fa);
    model_step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single write, x0 filter, forwarding youngest, non-matching lookup
    vecs[0]  = '{1, 5, 32'h1234_5678, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 1, 5, 1, 1, 1, 5, 32'h1234_5678, 1, 32'h1234_5678};
    vecs[2]  = '{0, 0, 0, 1, 5, 1, 0, 0, 0, 0, 0, 0};
    vecs[3]  = '{1, 0, 32'hFFFF_FFFF, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 7, 32'hA, 0, 7, 1, 0, 0, 0, 0, 0, 0};
    vecs[6]  = '{1, 7, 32'hB, 0, 7, 1, 1, 0, 7, 32'hA, 1, 32'hA};
    vecs[7]  = '{0, 0, 0, 1, 7, 0, 2, 1, 7, 32'hA, 1, 32'hB};
    vecs[8]  = '{0, 0, 0, 1, 7, 1, 1, 1, 7, 32'hB, 1, 32'hB};
    vecs[9]  = '{0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 9, 32'h99, 0, 9, 1, 0, 0, 0, 0, 0, 0};
    vecs[11] = '{0, 0, 0, 0, 3, 1, 1, 0, 9, 32'h99, 0, 0};
    vecs[12] = '{0, 0, 0, 1, 9, 1, 1, 1, 9, 32'h99, 1, 32'h99};
    vecs[13] = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};

    pmax = 0;
    rst_n = 1'b0;
    apply(1, 5, 32'hDEAD_BEEF, 1, 5);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_pending", pending, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].rd, vecs[i].d, vecs[i].we, vecs[i].fa);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].e_rdy);
      chk($sformatf("vec%0d_pending", i), pending, vecs[i].e_pend);
      chk($sformatf("vec%0d_wen", i), wen, vecs[i].e_wen);
      chk($sformatf("vec%0d_waddr", i), waddr, vecs[i].e_wa);
      chk($sformatf("vec%0d_wdata", i), wdata, vecs[i].e_wd);
      chk($sformatf("vec%0d_fwd_hit", i), fwd_hit, vecs[i].e_hit);
      chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].e_fd);
      model_step();
    end

    // Backpressure: third offer held off until the port drains the FIFO
    wr_log.delete();
    cyc(1, 1, 32'h11, 0, 0);
    cyc(1, 2, 32'h22, 0, 0);
    apply(1, 3, 32'h33, 0, 0);
    chk("bp_full_ready", in_ready, 0);
    model_step();
    cyc(1, 3, 32'h33, 1, 0);
    cyc(1, 3, 32'h33, 1, 3);
    cyc(0, 0, 0, 1, 3);
    cyc(0, 0, 0, 1, 0);
    chk("bp_write_count", wr_log.size(), 3);
    if (wr_log.size() == 3) begin
      chk("bp_order0", wr_log[0], 1);
      chk("bp_order1", wr_log[1], 2);
      chk("bp_order2", wr_log[2], 3);
    end

    // Wrap: ten back-to-back pushes drain one per cycle with no gaps
    wr_log.delete();
    pmax = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1, 5'(i), 32'h100 + 32'(i), 1, 5'(i));
      chk($sformatf("wrap_write%0d", i), wr_log.size(), i - 1);
    end
    cyc(0, 0, 0, 1, 0);
    chk("wrap_write_count", wr_log.size(), 10);
    chk("wrap_pending_max", pmax, 1);
    for (int i = 0; i < wr_log.size(); i++) begin
      chk($sformatf("wrap_order%0d", i), wr_log[i], i + 1);
    end

    // Mid-operation asynchronous reset with a full FIFO
    cyc(1, 20, 32'h2020, 0, 0);
    cyc(1, 21, 32'h2121, 0, 0);
    apply(0, 0, 0, 1, 20);
    chk("mid_full_pending", pending, 2);
    chk("mid_full_wen", wen, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", wen, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_waddr", waddr, 0);
    chk("mid_rst_fwd_hit", fwd_hit, 0);
    sb_q.delete();
    in_valid = 1'b1;
    in_rd    = 5'd22;
    in_data  = 32'h2222;
    @(posedge clk);
    #1;
    chk("mid_rst_ignore_valid", pending, 0);
    rst_n = 1'b1;
    wr_log.delete();
    cyc(1, 23, 32'h2323, 1, 20);
    cyc(0, 0, 0, 1, 20);
    cyc(0, 0, 0, 1, 21);
    chk("post_rst_write_count", wr_log.size(), 1);
    if (wr_log.size() == 1) chk("post_rst_write_addr", wr_log[0], 23);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
